// File: rtl/mha_attn_seq.sv
// Multi-head attention sequencer. For every head it runs S = Q*K^T on the external
// systolic array, scales and optionally causal-masks the scores, and pushes each row
// through the external softmax unit. It then runs O = P*V one column tile at a time
// and streams each output tile under valid/ready. Only the score/P buffer lives here.
module mha_attn_seq #(
   parameter int D_W       = 8,
   parameter int SEQ       = 16,
   parameter int D_K       = 128,
   parameter int H_NUM     = 4,
   parameter int SCALE_MUL = 3,
   parameter int SCALE_SH  = 5,
   localparam int N_TILE   = D_K / SEQ,
   localparam int HW       = (H_NUM > 1) ? $clog2(H_NUM) : 1,
   localparam int TW       = (N_TILE > 1) ? $clog2(N_TILE) : 1
) (
   input  logic                             I_CLK,
   input  logic                             I_ASYN_RSTN,
   input  logic                             I_START,
   input  logic                             I_CAUSAL,
   input  logic                             I_ABORT,
   output logic                             O_BUSY,
   output logic                             O_DONE,
   output logic                             O_SA_CLEARN,
   output logic                             O_SA_START,
   output logic                             O_SA_OP,
   output logic [HW-1:0]                    O_SA_HEAD,
   output logic [TW-1:0]                    O_SA_TILE,
   input  logic                             I_SA_VLD,
   input  logic [SEQ-1:0][SEQ-1:0][D_W-1:0] I_SA_RESULT,
   output logic [SEQ-1:0][SEQ-1:0][D_W-1:0] O_P_MAT,
   output logic                             O_SM_START,
   output logic [SEQ-1:0][D_W-1:0]          O_SM_ROW,
   input  logic                             I_SM_VLD,
   input  logic [SEQ-1:0][D_W-1:0]          I_SM_DATA,
   output logic                             O_OUT_VLD,
   input  logic                             I_OUT_RDY,
   output logic [HW-1:0]                    O_OUT_HEAD,
   output logic [TW-1:0]                    O_OUT_TILE,
   output logic [SEQ-1:0][SEQ-1:0][D_W-1:0] O_OUT_DATA
);

   localparam int RW = (SEQ > 1) ? $clog2(SEQ) : 1;
   localparam logic [HW-1:0] HEAD_LAST = HW'(H_NUM - 1);
   localparam logic [TW-1:0] TILE_LAST = TW'(N_TILE - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(SEQ - 1);
   localparam logic signed [2*D_W-1:0] MUL_W   = (2*D_W)'(SCALE_MUL);
   localparam logic signed [2*D_W-1:0] SAT_MAX = (2*D_W)'((1 << (D_W - 1)) - 1);
   localparam logic signed [2*D_W-1:0] SAT_MIN = (2*D_W)'(-(1 << (D_W - 1)));
   localparam logic [D_W-1:0] NEG_SAT = {1'b1, {(D_W - 1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE, ST_CLR_QK, ST_RUN_QK, ST_SCALE, ST_SM_ROW, ST_CLR_PV, ST_RUN_PV, ST_OUT
   } state_t;

   state_t                           state_q, state_d;
   logic                             causal_q, causal_d;
   logic [HW-1:0]                    head_q, head_d;
   logic [TW-1:0]                    tile_q, tile_d;
   logic [RW-1:0]                    row_q, row_d;
   logic [SEQ-1:0][SEQ-1:0][D_W-1:0] score_q, score_d;
   logic [SEQ-1:0][SEQ-1:0][D_W-1:0] outData_q, outData_d;
   logic                             outVld_q, outVld_d;
   logic                             done_q, done_d;
   logic                             saStart_q, saStart_d;
   logic                             smStart_q, smStart_d;
   logic                             abortClr_q, abortClr_d;

   // Fixed-point scale of one score: widen, multiply, arithmetic shift, saturate back to D_W.
   function automatic logic [D_W-1:0] scaleElem(input logic [D_W-1:0] s);
      logic signed [2*D_W-1:0] sExt;
      logic signed [2*D_W-1:0] prod;
      logic signed [2*D_W-1:0] shifted;
      sExt    = {{D_W{s[D_W-1]}}, s};
      prod    = sExt * MUL_W;
      shifted = prod >>> SCALE_SH;
      if (shifted > SAT_MAX)
         scaleElem = SAT_MAX[D_W-1:0];
      else if (shifted < SAT_MIN)
         scaleElem = SAT_MIN[D_W-1:0];
      else
         scaleElem = shifted[D_W-1:0];
   endfunction

   // State, counters, buffers and registered pulse outputs.
   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN) begin
         state_q    <= ST_IDLE;
         causal_q   <= 1'b0;
         head_q     <= '0;
         tile_q     <= '0;
         row_q      <= '0;
         score_q    <= '0;
         outData_q  <= '0;
         outVld_q   <= 1'b0;
         done_q     <= 1'b0;
         saStart_q  <= 1'b0;
         smStart_q  <= 1'b0;
         abortClr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         causal_q   <= causal_d;
         head_q     <= head_d;
         tile_q     <= tile_d;
         row_q      <= row_d;
         score_q    <= score_d;
         outData_q  <= outData_d;
         outVld_q   <= outVld_d;
         done_q     <= done_d;
         saStart_q  <= saStart_d;
         smStart_q  <= smStart_d;
         abortClr_q <= abortClr_d;
      end
   end

   // Next-state logic; abort overrides everything, pulses default low every cycle.
   always_comb begin
      state_d    = state_q;
      causal_d   = causal_q;
      head_d     = head_q;
      tile_d     = tile_q;
      row_d      = row_q;
      score_d    = score_q;
      outData_d  = outData_q;
      outVld_d   = outVld_q;
      done_d     = 1'b0;
      saStart_d  = 1'b0;
      smStart_d  = 1'b0;
      abortClr_d = 1'b0;
      if (I_ABORT) begin
         state_d    = ST_IDLE;
         outVld_d   = 1'b0;
         abortClr_d = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (I_START) begin
                  causal_d = I_CAUSAL;
                  head_d   = '0;
                  tile_d   = '0;
                  row_d    = '0;
                  state_d  = ST_CLR_QK;
               end
            end
            ST_CLR_QK: begin
               saStart_d = 1'b1;
               state_d   = ST_RUN_QK;
            end
            ST_RUN_QK: begin
               if (I_SA_VLD) begin
                  score_d = I_SA_RESULT;
                  state_d = ST_SCALE;
               end
            end
            ST_SCALE: begin
               for (int r = 0; r < SEQ; r++) begin
                  for (int c = 0; c < SEQ; c++) begin
                     score_d[r][c] = (causal_q && (c > r)) ? NEG_SAT : scaleElem(score_q[r][c]);
                  end
               end
               row_d     = '0;
               smStart_d = 1'b1;
               state_d   = ST_SM_ROW;
            end
            ST_SM_ROW: begin
               if (I_SM_VLD) begin
                  score_d[row_q] = I_SM_DATA;
                  if (row_q == ROW_LAST) begin
                     tile_d  = '0;
                     state_d = ST_CLR_PV;
                  end else begin
                     row_d     = row_q + RW'(1);
                     smStart_d = 1'b1;
                  end
               end
            end
            ST_CLR_PV: begin
               saStart_d = 1'b1;
               state_d   = ST_RUN_PV;
            end
            ST_RUN_PV: begin
               if (I_SA_VLD) begin
                  outData_d = I_SA_RESULT;
                  outVld_d  = 1'b1;
                  state_d   = ST_OUT;
               end
            end
            ST_OUT: begin
               if (outVld_q && I_OUT_RDY) begin
                  outVld_d = 1'b0;
                  if (tile_q != TILE_LAST) begin
                     tile_d  = tile_q + TW'(1);
                     state_d = ST_CLR_PV;
                  end else if (head_q != HEAD_LAST) begin
                     head_d  = head_q + HW'(1);
                     tile_d  = '0;
                     state_d = ST_CLR_QK;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign O_BUSY      = (state_q != ST_IDLE);
   assign O_DONE      = done_q;
   assign O_SA_CLEARN = !((state_q == ST_CLR_QK) || (state_q == ST_CLR_PV) || abortClr_q);
   assign O_SA_START  = saStart_q;
   assign O_SA_OP     = (state_q == ST_CLR_PV) || (state_q == ST_RUN_PV) || (state_q == ST_OUT);
   assign O_SA_HEAD   = head_q;
   assign O_SA_TILE   = tile_q;
   assign O_P_MAT     = score_q;
   assign O_SM_START  = smStart_q;
   assign O_SM_ROW    = score_q[row_q];
   assign O_OUT_VLD   = outVld_q;
   assign O_OUT_HEAD  = head_q;
   assign O_OUT_TILE  = tile_q;
   assign O_OUT_DATA  = outData_q;

endmodule

// File: tb/tb_mha_attn_seq.sv
// Bench for mha_attn_seq. Instance A (2 heads, 2 tiles, scale 3>>>5) carries the main
// sequence; instance B (1 head, 1 tile, scale 127>>>0) exercises saturation. Both share
// stimulus; useB selects which one is started and observed.
module tb_mha_attn_seq;

   localparam int D_W = 8;
   localparam int SEQ = 16;

   typedef logic [SEQ-1:0][D_W-1:0]          row_t;
   typedef logic [SEQ-1:0][SEQ-1:0][D_W-1:0] mat_t;

   typedef struct {
      logic useB;
      logic causal;
      int   qkVal;
      int   expDiag;
      int   expUpper;
      int   expLower;
   } scaleVec_t;

   typedef struct {
      int   head;
      int   tile;
      mat_t data;
   } outExp_t;

   logic clock = 1'b0;
   logic rstN;
   logic startIn, causalIn, abortIn, saVld, smVld, outRdy, useB;
   logic startA, startB;
   mat_t saResult;
   row_t smData;

   logic busyA, doneA, clearnA, saStartA, saOpA, smStartA, outVldA;
   logic [0:0] saHeadA, saTileA, outHeadA, outTileA;
   mat_t pMatA, outDataA;
   row_t smRowA;
   logic busyB, doneB, clearnB, saStartB, saOpB, smStartB, outVldB;
   logic [0:0] saHeadB, saTileB, outHeadB, outTileB;
   mat_t pMatB, outDataB;
   row_t smRowB;

   logic busyS, doneS, clearnS, saStartS, saOpS, smStartS, outVldS;
   logic [0:0] saHeadS, saTileS, outHeadS, outTileS;
   mat_t pMatS, outDataS;
   row_t smRowS;

   int testsRun = 0;
   int testsFailed = 0;
   int doneCount = 0;
   outExp_t sbQ[$];
   scaleVec_t vecs[9];

   assign startA   = startIn & ~useB;
   assign startB   = startIn & useB;
   assign busyS    = useB ? busyB : busyA;
   assign doneS    = useB ? doneB : doneA;
   assign clearnS  = useB ? clearnB : clearnA;
   assign saStartS = useB ? saStartB : saStartA;
   assign saOpS    = useB ? saOpB : saOpA;
   assign saHeadS  = useB ? saHeadB : saHeadA;
   assign saTileS  = useB ? saTileB : saTileA;
   assign pMatS    = useB ? pMatB : pMatA;
   assign smStartS = useB ? smStartB : smStartA;
   assign smRowS   = useB ? smRowB : smRowA;
   assign outVldS  = useB ? outVldB : outVldA;
   assign outHeadS = useB ? outHeadB : outHeadA;
   assign outTileS = useB ? outTileB : outTileA;
   assign outDataS = useB ? outDataB : outDataA;

   mha_attn_seq #(.D_W(8), .SEQ(16), .D_K(32), .H_NUM(2), .SCALE_MUL(3), .SCALE_SH(5)) dutA (
      .I_CLK(clock), .I_ASYN_RSTN(rstN), .I_START(startA), .I_CAUSAL(causalIn), .I_ABORT(abortIn),
      .O_BUSY(busyA), .O_DONE(doneA), .O_SA_CLEARN(clearnA), .O_SA_START(saStartA), .O_SA_OP(saOpA),
      .O_SA_HEAD(saHeadA), .O_SA_TILE(saTileA), .I_SA_VLD(saVld), .I_SA_RESULT(saResult),
      .O_P_MAT(pMatA), .O_SM_START(smStartA), .O_SM_ROW(smRowA), .I_SM_VLD(smVld), .I_SM_DATA(smData),
      .O_OUT_VLD(outVldA), .I_OUT_RDY(outRdy), .O_OUT_HEAD(outHeadA), .O_OUT_TILE(outTileA),
      .O_OUT_DATA(outDataA)
   );

   mha_attn_seq #(.D_W(8), .SEQ(16), .D_K(16), .H_NUM(1), .SCALE_MUL(127), .SCALE_SH(0)) dutB (
      .I_CLK(clock), .I_ASYN_RSTN(rstN), .I_START(startB), .I_CAUSAL(causalIn), .I_ABORT(abortIn),
      .O_BUSY(busyB), .O_DONE(doneB), .O_SA_CLEARN(clearnB), .O_SA_START(saStartB), .O_SA_OP(saOpB),
      .O_SA_HEAD(saHeadB), .O_SA_TILE(saTileB), .I_SA_VLD(saVld), .I_SA_RESULT(saResult),
      .O_P_MAT(pMatB), .O_SM_START(smStartB), .O_SM_ROW(smRowB), .I_SM_VLD(smVld), .I_SM_DATA(smData),
      .O_OUT_VLD(outVldB), .I_OUT_RDY(outRdy), .O_OUT_HEAD(outHeadB), .O_OUT_TILE(outTileB),
      .O_OUT_DATA(outDataB)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Count completion pulses away from the active edge.
   always @(negedge clock) begin
      if (doneA | doneB) doneCount++;
   end

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached before the summary");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkRow(input string name, input row_t act, input row_t exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkMat(input string name, input mat_t act, input mat_t exp);
      int fr;
      int fc;
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         fr = 0;
         fc = 0;
         for (int r = SEQ - 1; r >= 0; r--)
            for (int c = SEQ - 1; c >= 0; c--)
               if (act[r][c] !== exp[r][c]) begin
                  fr = r;
                  fc = c;
               end
         $display("[TB] FAIL %s: element [%0d][%0d] got %0d, expected %0d", name, fr, fc,
                  $signed(act[fr][fc]), $signed(exp[fr][fc]));
      end
   endtask

   function automatic logic sigSel(input int which);
      case (which)
         0:       return saStartS;
         1:       return smStartS;
         default: return outVldS;
      endcase
   endfunction

   // Wait (bounded) for a DUT pulse; an expired bound counts as a failure.
   task automatic waitSig(input int which, input string name, output int cyc);
      cyc = 0;
      while (!sigSel(which) && cyc < 40) begin
         tick();
         cyc++;
      end
      if (!sigSel(which)) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: no pulse after %0d cycles, expected one", name, cyc);
      end
   endtask

   // Softmax stand-in: returns a distinct recognisable pattern per row.
   function automatic row_t pRow(input int r);
      row_t p;
      for (int c = 0; c < SEQ; c++) p[c] = 8'(r * SEQ + c);
      return p;
   endfunction

   // One Q*K^T + scale/mask + softmax pass; ends on the first RUN_PV cycle unless aborted.
   task automatic doQk(input logic withStart, input logic causal, input int head, input int qkVal,
                       input int expDiag, input int expUpper, input int expLower, input int abortRow);
      int   cyc;
      row_t expRow;
      mat_t qk;
      mat_t pExp;
      if (withStart) begin
         startIn  = 1'b1;
         causalIn = causal;
         tick();
         startIn  = 1'b0;
         checkInt("clearn low in CLR_QK", clearnS, 0);
         waitSig(0, "qk sa start", cyc);
         checkInt("start to qk sa_start latency", cyc + 1, 2);
      end else begin
         waitSig(0, "next head qk sa start", cyc);
      end
      checkInt("qk op", saOpS, 0);
      checkInt("qk head", saHeadS, head);
      checkInt("qk tile", saTileS, 0);
      for (int r = 0; r < SEQ; r++)
         for (int c = 0; c < SEQ; c++) qk[r][c] = 8'(qkVal);
      saResult = qk;
      saVld    = 1'b1;
      tick();
      saVld    = 1'b0;
      waitSig(1, "first sm start", cyc);
      checkInt("qk sa_vld to sm_start latency", cyc + 1, 2);
      for (int r = 0; r < SEQ; r++) begin
         if (r > 0) checkInt($sformatf("sm start row %0d", r), smStartS, 1);
         for (int c = 0; c < SEQ; c++)
            expRow[c] = (c > r) ? 8'(expUpper) : ((c == r) ? 8'(expDiag) : 8'(expLower));
         checkRow($sformatf("sm row %0d", r), smRowS, expRow);
         if (r == abortRow) begin
            abortIn = 1'b1;
            tick();
            abortIn = 1'b0;
            checkInt("busy after abort", busyS, 0);
            checkInt("clearn low after abort", clearnS, 0);
            tick();
            checkInt("clearn released after abort", clearnS, 1);
            return;
         end
         if (r == 3) begin
            tick();
            tick();
            checkInt("sm start is a single pulse", smStartS, 0);
            checkRow("sm row 3 held", smRowS, expRow);
         end
         smData = pRow(r);
         smVld  = 1'b1;
         tick();
         smVld  = 1'b0;
      end
      waitSig(0, "pv sa start", cyc);
      checkInt("last sm_vld to pv sa_start latency", cyc + 1, 2);
      checkInt("pv op", saOpS, 1);
      checkInt("pv head", saHeadS, head);
      checkInt("pv tile 0", saTileS, 0);
      for (int r = 0; r < SEQ; r++) pExp[r] = pRow(r);
      checkMat("p matrix", pMatS, pExp);
   endtask

   // One P*V tile: feed the SA result, push the expectation, drain it through the handshake.
   task automatic doPv(input int head, input int tile, input int holdCycles, input logic finalTile);
      int      cyc;
      mat_t    res;
      outExp_t e;
      if (tile > 0) begin
         waitSig(0, "pv sa start", cyc);
         checkInt("pv op", saOpS, 1);
         checkInt("pv head", saHeadS, head);
         checkInt("pv tile", saTileS, tile);
      end
      for (int r = 0; r < SEQ; r++)
         for (int c = 0; c < SEQ; c++) res[r][c] = 8'(7 + head * 32 + tile * 16 + r + c);
      e.head = head;
      e.tile = tile;
      e.data = res;
      sbQ.push_back(e);
      saResult = res;
      saVld    = 1'b1;
      tick();
      saVld    = 1'b0;
      checkInt("pv sa_vld to out_vld latency", outVldS, 1);
      for (int i = 0; i < holdCycles; i++) begin
         tick();
         checkInt("out_vld held under backpressure", outVldS, 1);
         checkMat("out data held under backpressure", outDataS, res);
      end
      outRdy = 1'b1;
      if (sbQ.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard: output seen, expected queue empty");
      end else begin
         e = sbQ.pop_front();
         checkInt("out head", outHeadS, e.head);
         checkInt("out tile", outTileS, e.tile);
         checkMat("out data", outDataS, e.data);
      end
      tick();
      outRdy = 1'b0;
      checkInt("out_vld drops after handshake", outVldS, 0);
      if (finalTile) begin
         checkInt("done pulse after last tile", doneS, 1);
         checkInt("idle after last tile", busyS, 0);
         tick();
         checkInt("done lasts one cycle", doneS, 0);
      end else begin
         checkInt("no done before last tile", doneS, 0);
         checkInt("busy between tiles", busyS, 1);
      end
   endtask

   task automatic applyStimulus();
      int base;
      base = doneCount;
      for (int h = 0; h < 2; h++) begin
         doQk(h == 0, 1'b0, h, 64, 6, 6, 6, -1);
         for (int t = 0; t < 2; t++)
            doPv(h, t, (h == 0 && t == 0) ? 5 : 0, (h == 1 && t == 1));
      end
      checkInt("done pulses in full run", doneCount - base, 1);
      checkInt("scoreboard drained", sbQ.size(), 0);
   endtask

   task automatic checkOutput(input string tag);
      checkInt({tag, " busy"}, busyS, 0);
      checkInt({tag, " done"}, doneS, 0);
      checkInt({tag, " sa clearn"}, clearnS, 1);
      checkInt({tag, " sa start"}, saStartS, 0);
      checkInt({tag, " sa op"}, saOpS, 0);
      checkInt({tag, " sa head"}, saHeadS, 0);
      checkInt({tag, " sa tile"}, saTileS, 0);
      checkInt({tag, " sm start"}, smStartS, 0);
      checkRow({tag, " sm row"}, smRowS, '0);
      checkInt({tag, " out vld"}, outVldS, 0);
      checkMat({tag, " p matrix"}, pMatS, '0);
      checkMat({tag, " out data"}, outDataS, '0);
   endtask

   initial begin
      int base;
      vecs[0] = '{1'b0, 1'b0,   64,    6,    6,    6};
      vecs[1] = '{1'b0, 1'b1,   10,    0, -128,    0};
      vecs[2] = '{1'b0, 1'b0, -100,  -10,  -10,  -10};
      vecs[3] = '{1'b0, 1'b1,  127,   11, -128,   11};
      vecs[4] = '{1'b0, 1'b1, -128,  -12, -128,  -12};
      vecs[5] = '{1'b1, 1'b0,  127,  127,  127,  127};
      vecs[6] = '{1'b1, 1'b0, -128, -128, -128, -128};
      vecs[7] = '{1'b1, 1'b0,   -1, -127, -127, -127};
      vecs[8] = '{1'b1, 1'b1,  100,  127, -128,  127};

      rstN     = 1'b0;
      startIn  = 1'b0;
      causalIn = 1'b0;
      abortIn  = 1'b0;
      saVld    = 1'b0;
      smVld    = 1'b0;
      outRdy   = 1'b0;
      useB     = 1'b0;
      saResult = '0;
      smData   = '0;
      repeat (3) tick();
      checkOutput("reset A");
      useB = 1'b1;
      checkOutput("reset B");
      useB = 1'b0;
      rstN = 1'b1;
      tick();

      base = doneCount;
      foreach (vecs[i]) begin
         useB = vecs[i].useB;
         doQk(1'b1, vecs[i].causal, 0, vecs[i].qkVal, vecs[i].expDiag, vecs[i].expUpper,
              vecs[i].expLower, -1);
         abortIn = 1'b1;
         tick();
         abortIn = 1'b0;
         checkInt("idle after abort in RUN_PV", busyS, 0);
         checkInt("no out_vld after abort", outVldS, 0);
         tick();
      end
      useB = 1'b0;

      doQk(1'b1, 1'b0, 0, 64, 6, 6, 6, 7);
      checkInt("no done from aborted runs", doneCount - base, 0);

      applyStimulus();

      doQk(1'b1, 1'b1, 0, 10, 0, -128, 0, -1);
      tick();
      checkInt("still busy in RUN_PV", busyS, 1);
      #3 rstN = 1'b0;
      #1;
      checkOutput("async reset in RUN_PV");
      rstN = 1'b1;
      tick();
      checkInt("idle after reset release", busyS, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
